zoled_gram_page_unpacker: RTL and testbench
===========================================

// Module: zoled_gram_page_unpacker
// PURPOSE
// - Reverse of the pixel->page/bitmask mapping. Reads SSD1306-style page bytes
//   (8 vertical pixels per byte) from the OLED GRAM and emits a pixel stream:
//   X, Y and on/off, under valid/ready flow control.
// - Sits between the GRAM and readback consumers: frame CRC, UART dump, self-test compare.
// PARAMETERS
// - COLS      128  columns per page; X width = clog2(COLS)
// - PAGES     8    pages per frame; Y = page*8+bit, Y width = clog2(PAGES*8)
// - RAM_LAT   1    GRAM read latency in cycles, 1..3
// PORTS
// - clk         in   1   system clock
// - rst_n       in   1   asynchronous active-low reset
// - iStart      in   1   request pulse; sampled only in IDLE
// - iFullFrame  in   1   1 = all pages 0..PAGES-1, 0 = single page iPage
// - iPage       in   3   page for single-page mode
// - oBusy       out  1   high from accepted iStart until oDone
// - oDone       out  1   1-cycle pulse after the last pixel is accepted
// - oErr        out  1   1-cycle pulse when a request is rejected
// - oRamRd      out  1   GRAM read strobe
// - oRamAddr    out  10  GRAM byte address = page*COLS + col
// - iRamData    in   8   GRAM byte, valid RAM_LAT cycles after oRamRd
// - oPixValid   out  1   pixel valid
// - iPixReady   in   1   consumer ready
// - oPixX       out  7   pixel column
// - oPixY       out  6   pixel row
// - oPixOn      out  1   pixel value (byte bit)
// BEHAVIOUR
// - Reset is asynchronous. All outputs reset to 0. FSM resets to IDLE.
// - FSM states: IDLE -> RD -> WAIT -> EMIT -> (RD | DONE) -> IDLE.
// - IDLE, iStart=1:
//   - Latch the page range: first=last=iPage, or 0..PAGES-1 when iFullFrame=1.
//   - Clear col and bit. Set oBusy. Go to RD.
//   - If iFullFrame=0 and iPage>=PAGES: oErr pulse, stay in IDLE, oBusy stays 0.
// - RD: oRamRd=1 for exactly 1 cycle with oRamAddr, then WAIT.
// - WAIT: hold RAM_LAT cycles. Capture iRamData into a byte register on the last WAIT cycle, then go to EMIT.
// - EMIT:
//   - oPixValid=1; oPixOn=byte[bit]; oPixX=col; oPixY=page*8+bit.
//   - bit advances only on the cycle oPixValid&&iPixReady.
// - Stream order:
//   - bit 0..7 (Y ascending), then col 0..COLS-1, then page first..last.
//   - This is column-major within a page, matching the GRAM layout.
// - Backpressure: while oPixValid&&!iPixReady, oPixX/oPixY/oPixOn are held stable.
//   oPixValid never drops before the handshake completes.
// - Wrap-around:
//   - After bit 7 is accepted: col+1, return to RD.
//   - After col COLS-1: col=0, page+1.
//   - After the last page's last pixel is accepted: DONE.
// - DONE: oDone=1 and oBusy=0 on the same cycle, then IDLE.
//   No pixel is emitted in DONE.
// - Throughput: 8 pixels per 10+RAM_LAT cycles with iPixReady tied high. No prefetch.
// - iStart while oBusy=1 is ignored; no oErr.
// - Reset asserted mid-frame aborts immediately.
//   - oPixValid, oRamRd and oBusy drop asynchronously.
//   - No oDone. The next iStart restarts from scratch.
// - Widths:
//   - Y = {page,bit}, a concatenation with no carry.
//   - The address multiply is a shift when COLS is a power of two, otherwise a constant multiply.
//   - The address is computed in 10 bits and never overflows for the defaults.
// STRUCTURE
// - Shared package zoled_pkg:
//   - OLED_COLS=128, OLED_PAGES=8, PAGE_ROWS=8.
//   - The FSM state enum, shared with the page mapper.
//   - Function page_bit_to_y(page,bit).
// - One natural sub-module: zoled_pix_out_reg.
//   - A valid/ready output register that holds X/Y/On under stall.
// - FSM, counters and address generation stay in this module.
// TESTING
// - Single page: GRAM page 2 col 0=8'h81, rest 0; iPage=2, iFullFrame=0, ready=1.
//   -> 1024 pixels; (0,16) and (0,23) on, all others off.
//   -> oDone exactly once, 1024*(10+RAM_LAT)/8 cycles after start.
// - Full frame: GRAM byte i = i[7:0].
//   -> 8192 pixels in order page,col,bit.
//   -> oPixOn == byte(page*128+col)[bit] for every pixel; oRamRd count = 1024.
// - Backpressure: random iPixReady at 30% duty.
//   -> X/Y/On are stable whenever valid&&!ready.
//   -> The sequence is identical to the ready=1 run; no pixel is dropped or duplicated.
// - Wrap-around: full frame, check the last col of page 0 then page 1.
//   -> X=127,Y=7 followed by X=0,Y=8.
//   -> Last pixel is X=127,Y=63, then the oDone pulse.
// - Illegal and busy requests: iStart with iPage=3'd7 when PAGES=4 -> oErr pulse, no oRamRd.
//   -> A second iStart mid-frame has no effect.
// - Mid-frame reset: assert rst_n=0 at pixel 500.
//   -> All outputs are 0 the same cycle; no oDone.
//   -> A restart streams again from X=0,Y=first*8.

Source files
------------

// File: rtl/zoled_gram_page_unpacker_pkg.sv
// Shared definitions for the OLED GRAM readback path: panel geometry,
// the controller state encoding and the page/bit to row mapping.
package zoled_pkg;

   localparam int OLED_COLS  = 128;
   localparam int OLED_PAGES = 8;
   localparam int PAGE_ROWS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_EMIT,
      ST_DONE
   } zoled_state_e;

   // A row index is simply the page number with the bit number appended.
   // It is a plain concatenation, so no carry can ever cross into the page field.
   function automatic logic [5:0] page_bit_to_y(input logic [2:0] page, input logic [2:0] bitIdx);
      return {page, bitIdx};
   endfunction

endpackage

// File: rtl/zoled_gram_page_unpacker_pix_out_reg.sv
// Registered valid/ready pixel output stage. A new pixel may only be loaded
// when the stage is empty or is being drained on the same cycle, so X/Y/On
// stay frozen for as long as the consumer stalls.
module zoled_pix_out_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       ready_i,
   input  logic [6:0] x_i,
   input  logic [5:0] y_i,
   input  logic       on_i,
   output logic       valid_o,
   output logic [6:0] x_o,
   output logic [5:0] y_o,
   output logic       on_o
);

   logic       valid_q;
   logic [6:0] x_q;
   logic [5:0] y_q;
   logic       on_q;

   // Load a new pixel, or release the current one once it has been taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         on_q    <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         x_q     <= x_i;
         y_q     <= y_i;
         on_q    <= on_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign on_o    = on_q;

endmodule

// File: rtl/zoled_gram_page_unpacker.sv
// Reads SSD1306-style page bytes out of the OLED GRAM and turns each byte
// into eight vertical pixels (X, Y, on/off) on a valid/ready stream.
// One byte is fetched at a time with no prefetch: RD, WAIT for the RAM, then
// EMIT the eight bits before the next read is issued.
module zoled_gram_page_unpacker
   import zoled_pkg::*;
#(
   parameter int COLS    = OLED_COLS,
   parameter int PAGES   = OLED_PAGES,
   parameter int RAM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iStart,
   input  logic       iFullFrame,
   input  logic [2:0] iPage,
   output logic       oBusy,
   output logic       oDone,
   output logic       oErr,
   output logic       oRamRd,
   output logic [9:0] oRamAddr,
   input  logic [7:0] iRamData,
   output logic       oPixValid,
   input  logic       iPixReady,
   output logic [6:0] oPixX,
   output logic [5:0] oPixY,
   output logic       oPixOn
);

   zoled_state_e state_q;
   logic [2:0]   page_q;
   logic [2:0]   lastPage_q;
   logic [6:0]   col_q;
   logic [2:0]   bit_q;
   logic [1:0]   waitCnt_q;
   logic [7:0]   byte_q;
   logic         busy_q;
   logic         done_q;
   logic         err_q;
   logic         ramRd_q;
   logic [9:0]   addr_q;

   logic         pixAccept;
   logic         lastBit;
   logic         pushPix;
   logic [2:0]   pushBit;
   logic [2:0]   startPage;
   logic         badPage;

   // Byte address of a page/column pair; a shift for power-of-two widths.
   function automatic logic [9:0] calcAddr(input logic [2:0] pg, input logic [6:0] cl);
      return 10'(pg) * 10'(COLS) + 10'(cl);
   endfunction

   assign pixAccept = oPixValid && iPixReady;
   assign lastBit   = (bit_q == 3'(PAGE_ROWS - 1));
   assign startPage = iFullFrame ? 3'd0 : iPage;
   assign badPage   = !iFullFrame && (int'(iPage) >= PAGES);

   // The first bit of a byte is pushed into an empty output stage; each later
   // bit is pushed on the cycle its predecessor is handed over.
   assign pushPix = (state_q == ST_EMIT) && (!oPixValid || (iPixReady && !lastBit));
   assign pushBit = oPixValid ? bit_q + 3'd1 : bit_q;

   zoled_pix_out_reg uPixOut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (pushPix),
      .ready_i (iPixReady),
      .x_i     (col_q),
      .y_i     (page_bit_to_y(page_q, pushBit)),
      .on_i    (byte_q[pushBit]),
      .valid_o (oPixValid),
      .x_o     (oPixX),
      .y_o     (oPixY),
      .on_o    (oPixOn)
   );

   // Controller: request decode, byte fetch, bit/column/page walk and completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         page_q     <= '0;
         lastPage_q <= '0;
         col_q      <= '0;
         bit_q      <= '0;
         waitCnt_q  <= '0;
         byte_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ramRd_q    <= 1'b0;
         addr_q     <= '0;
      end else begin
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ramRd_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (iStart) begin
                  if (badPage) begin
                     err_q <= 1'b1;
                  end else begin
                     page_q     <= startPage;
                     lastPage_q <= iFullFrame ? 3'(PAGES - 1) : iPage;
                     col_q      <= '0;
                     bit_q      <= '0;
                     busy_q     <= 1'b1;
                     ramRd_q    <= 1'b1;
                     addr_q     <= calcAddr(startPage, 7'd0);
                     state_q    <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               waitCnt_q <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (waitCnt_q == 2'(RAM_LAT - 1)) begin
                  byte_q  <= iRamData;
                  state_q <= ST_EMIT;
               end else begin
                  waitCnt_q <= waitCnt_q + 2'd1;
               end
            end
            ST_EMIT: begin
               if (pixAccept) begin
                  if (!lastBit) begin
                     bit_q <= bit_q + 3'd1;
                  end else begin
                     bit_q <= '0;
                     if (col_q == 7'(COLS - 1)) begin
                        col_q <= '0;
                        if (page_q == lastPage_q) begin
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                           state_q <= ST_DONE;
                        end else begin
                           page_q  <= page_q + 3'd1;
                           ramRd_q <= 1'b1;
                           addr_q  <= calcAddr(page_q + 3'd1, 7'd0);
                           state_q <= ST_RD;
                        end
                     end else begin
                        col_q   <= col_q + 7'd1;
                        ramRd_q <= 1'b1;
                        addr_q  <= calcAddr(page_q, col_q + 7'd1);
                        state_q <= ST_RD;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oErr     = err_q;
   assign oRamRd   = ramRd_q;
   assign oRamAddr = addr_q;

endmodule

// File: tb/tb_zoled_gram_page_unpacker.sv
// Scoreboard bench for the GRAM page unpacker: a GRAM model with configurable
// latency, a randomised consumer, a reference stream built straight from the
// page/bit/column layout, and a monitor that pops and compares every pixel.
module tb_zoled_gram_page_unpacker;

   localparam int LAT   = 2;
   localparam int COLS  = 128;
   localparam int PAGES = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iStart = 1'b0;
   logic       iFullFrame = 1'b0;
   logic [2:0] iPage = 3'd0;
   logic       oBusy, oDone, oErr, oRamRd;
   logic [9:0] oRamAddr;
   logic [7:0] iRamData;
   logic       oPixValid;
   logic       iPixReady = 1'b1;
   logic [6:0] oPixX;
   logic [5:0] oPixY;
   logic       oPixOn;

   // Second, smaller instance used only to exercise the illegal-page path.
   logic       iStart2 = 1'b0;
   logic [2:0] iPage2 = 3'd0;
   logic       oBusy2, oDone2, oErr2, oRamRd2;
   logic [9:0] oRamAddr2;
   logic       oPixValid2;
   logic [6:0] oPixX2;
   logic [5:0] oPixY2;
   logic       oPixOn2;

   logic [7:0]  gram [0:1023];
   logic [7:0]  pipe [0:LAT-1];
   logic [13:0] expQ [$];
   logic [12:0] onPos [$];

   int checks = 0;
   int errors = 0;
   int pixCount, rdCount, doneCount, errCount, onCount, rd2Count;
   logic [12:0] p0, p1023, p1024, lastXY;
   logic        stallQ = 1'b0;
   logic [13:0] stallPix;
   logic        bpMode = 1'b0;
   int          cyc;

   always #5 clk = ~clk;

   zoled_gram_page_unpacker #(.COLS(COLS), .PAGES(PAGES), .RAM_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .iStart(iStart), .iFullFrame(iFullFrame), .iPage(iPage),
      .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oRamRd(oRamRd), .oRamAddr(oRamAddr),
      .iRamData(iRamData), .oPixValid(oPixValid), .iPixReady(iPixReady),
      .oPixX(oPixX), .oPixY(oPixY), .oPixOn(oPixOn)
   );

   zoled_gram_page_unpacker #(.COLS(4), .PAGES(4), .RAM_LAT(1)) dutSmall (
      .clk(clk), .rst_n(rst_n), .iStart(iStart2), .iFullFrame(1'b0), .iPage(iPage2),
      .oBusy(oBusy2), .oDone(oDone2), .oErr(oErr2), .oRamRd(oRamRd2), .oRamAddr(oRamAddr2),
      .iRamData(8'h00), .oPixValid(oPixValid2), .iPixReady(1'b1),
      .oPixX(oPixX2), .oPixY(oPixY2), .oPixOn(oPixOn2)
   );

   // GRAM model: data appears LAT cycles after a read strobe; garbage otherwise
   // so that a mistimed capture is visible.
   always @(posedge clk) begin
      pipe[0] <= oRamRd ? gram[oRamAddr] : 8'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign iRamData = pipe[LAT-1];

   // Consumer: always ready, or ready about 30% of the time under backpressure.
   always @(posedge clk) begin
      #1;
      iPixReady = bpMode ? ($urandom_range(0, 99) < 30) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: checks held data during stalls, pops the scoreboard on every
   // handshake and tallies strobes and pulses.
   always @(negedge clk) begin
      if (!rst_n) begin
         stallQ = 1'b0;
      end else begin
         if (stallQ)
            checkOutput("stall_hold", {oPixValid, oPixX, oPixY, oPixOn}, {1'b1, stallPix});
         if (oPixValid && iPixReady) begin
            if (expQ.size() == 0)
               checkOutput("unexpected_pixel", {oPixX, oPixY, oPixOn}, 32'hFFFF_FFFF);
            else
               checkOutput("pixel", {oPixX, oPixY, oPixOn}, expQ.pop_front());
            if (pixCount == 0)    p0    = {oPixX, oPixY};
            if (pixCount == 1023) p1023 = {oPixX, oPixY};
            if (pixCount == 1024) p1024 = {oPixX, oPixY};
            lastXY = {oPixX, oPixY};
            if (oPixOn) begin
               onCount++;
               onPos.push_back({oPixX, oPixY});
            end
            pixCount++;
         end
         stallQ   = oPixValid && !iPixReady;
         stallPix = {oPixX, oPixY, oPixOn};
         if (oRamRd)  rdCount++;
         if (oDone)   doneCount++;
         if (oErr)    errCount++;
         if (oRamRd2) rd2Count++;
      end
   end

   task automatic resetCounters();
      pixCount = 0; rdCount = 0; doneCount = 0; errCount = 0; onCount = 0; rd2Count = 0;
      onPos.delete();
   endtask

   // Build the expected stream (page, then column, then bit) and pulse iStart.
   task automatic applyStimulus(input logic full, input logic [2:0] page);
      int first, last;
      first = full ? 0 : int'(page);
      last  = full ? PAGES - 1 : int'(page);
      for (int p = first; p <= last; p++)
         for (int c = 0; c < COLS; c++)
            for (int b = 0; b < 8; b++)
               expQ.push_back({7'(c), 6'(p * 8 + b), gram[p * COLS + c][b]});
      @(posedge clk); #1;
      iFullFrame = full;
      iPage      = page;
      iStart     = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
   endtask

   // Count edges until oDone shows up, within a budget.
   task automatic waitDone(input int budget, output int cycles);
      cycles = 0;
      while (cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
         if (oDone) break;
      end
      checkOutput("done_seen", {31'd0, oDone}, 32'd1);
      checkOutput("done_busy_low", {31'd0, oBusy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset state of both instances.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {oBusy, oDone, oErr, oRamRd, oPixValid, oRamAddr, oPixX, oPixY, oPixOn}, 32'd0);
      checkOutput("reset_outputs_small",
                  {oBusy2, oDone2, oErr2, oRamRd2, oPixValid2, oRamAddr2, oPixX2, oPixY2, oPixOn2}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Single page with two lit pixels in column 0.
      for (int i = 0; i < 1024; i++) gram[i] = 8'h00;
      gram[2 * COLS] = 8'h81;
      resetCounters();
      applyStimulus(1'b0, 3'd2);
      waitDone(4000, cyc);
      checkOutput("single_latency", cyc, 1024 * (10 + LAT) / 8);
      checkOutput("single_pixels", pixCount, 1024);
      checkOutput("single_on_count", onCount, 2);
      if (onPos.size() >= 2) begin
         checkOutput("single_on0", {19'd0, onPos[0]}, {19'd0, 7'd0, 6'd16});
         checkOutput("single_on1", {19'd0, onPos[1]}, {19'd0, 7'd0, 6'd23});
      end
      checkOutput("single_done_count", doneCount, 1);
      checkOutput("single_rd_count", rdCount, 128);
      checkOutput("single_queue_empty", expQ.size(), 0);

      // Full frame, byte i holds i[7:0], consumer always ready.
      for (int i = 0; i < 1024; i++) gram[i] = 8'(i);
      resetCounters();
      applyStimulus(1'b1, 3'd0);
      waitDone(20000, cyc);
      checkOutput("full_latency", cyc, 8192 * (10 + LAT) / 8);
      checkOutput("full_pixels", pixCount, 8192);
      checkOutput("full_rd_count", rdCount, 1024);
      checkOutput("full_done_count", doneCount, 1);
      checkOutput("full_queue_empty", expQ.size(), 0);
      checkOutput("wrap_last_col_p0", {19'd0, p1023}, {19'd0, 7'd127, 6'd7});
      checkOutput("wrap_first_col_p1", {19'd0, p1024}, {19'd0, 7'd0, 6'd8});
      checkOutput("last_pixel", {19'd0, lastXY}, {19'd0, 7'd127, 6'd63});

      // Same frame under 30% backpressure, plus an iStart while busy.
      bpMode = 1'b1;
      resetCounters();
      applyStimulus(1'b1, 3'd0);
      repeat (300) @(posedge clk);
      #1;
      iFullFrame = 1'b0; iPage = 3'd5; iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      waitDone(70000, cyc);
      bpMode = 1'b0;
      checkOutput("bp_pixels", pixCount, 8192);
      checkOutput("bp_err_count", errCount, 0);
      checkOutput("bp_done_count", doneCount, 1);
      checkOutput("bp_rd_count", rdCount, 1024);
      checkOutput("bp_queue_empty", expQ.size(), 0);

      // Mid-frame reset at pixel 500, then a clean restart of the same page.
      for (int i = 0; i < 1024; i++) gram[i] = 8'($urandom);
      resetCounters();
      applyStimulus(1'b0, 3'd4);
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pixCount >= 500) break;
      end
      checkOutput("abort_reached_500", {31'd0, pixCount >= 500}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_outputs",
                  {oBusy, oDone, oErr, oRamRd, oPixValid, oRamAddr, oPixX, oPixY, oPixOn}, 32'd0);
      expQ.delete();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_no_done", doneCount, 0);
      @(negedge clk) rst_n = 1'b1;
      resetCounters();
      applyStimulus(1'b0, 3'd4);
      waitDone(4000, cyc);
      checkOutput("restart_first_pixel", {19'd0, p0}, {19'd0, 7'd0, 6'd32});
      checkOutput("restart_pixels", pixCount, 1024);
      checkOutput("restart_queue_empty", expQ.size(), 0);

      // Illegal page on the four-page instance.
      resetCounters();
      @(posedge clk); #1;
      iPage2 = 3'd7; iStart2 = 1'b1;
      @(posedge clk); #1;
      iStart2 = 1'b0;
      checkOutput("illegal_err_pulse", {31'd0, oErr2}, 32'd1);
      checkOutput("illegal_busy", {31'd0, oBusy2}, 32'd0);
      @(posedge clk); #1;
      checkOutput("illegal_err_single", {31'd0, oErr2}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("illegal_no_read", rd2Count, 0);
      checkOutput("illegal_still_idle", {31'd0, oBusy2}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
